skip_subtractor_serial: RTL and testbench

//  Group-serial carry-skip subtractor: d = a - b - bi, one GROUP-bit slice per clock.

---
 rtl/skip_subtractor_serial.sv | 115 +++++++++++
 tb/tb_skip_subtractor_serial.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/skip_subtractor_serial.sv
// Group-serial carry-skip subtractor: d = a - b - bi, one GROUP-bit slice
// per clock, computed as a + ~b + ~bi with a per-group skip bypass.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b, bi); ready only in IDLE
//   out_valid / out_ready result handshake (d, bo, ov, skip); valid in DONE
//   d     difference modulo 2^WIDTH
//   bo    borrow-out, 1 iff a < b + bi (unsigned)
//   ov    signed overflow
//   skip  bit g set when group g carry took the bypass path
module skip_subtractor_serial #(
  parameter  int WIDTH = 8,
  parameter  int GROUP = 4,
  localparam int NG    = WIDTH / GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov,
  output logic [NG-1:0]    skip
);

  localparam int GW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             c_q, bo_q, ov_q;
  logic [NG-1:0]    skip_q;
  logic [GW-1:0]    g_q;

  logic [GROUP-1:0] ag, bgn;
  logic [GROUP:0]   sum;
  logic             p, c_d, ov_d, last;
  int               base;

  always_comb begin
    base = int'(g_q) * GROUP;
    ag   = a_q[base +: GROUP];
    bgn  = ~b_q[base +: GROUP];
    sum  = {1'b0, ag} + {1'b0, bgn} + {{GROUP{1'b0}}, c_q};
    // All bits propagate iff a_g == b_g; carry then bypasses the ripple.
    p    = &(ag ^ bgn);
    c_d  = p ? c_q : sum[GROUP];
    // The last group holds the MSB, so its fresh sum bit is d[W-1].
    ov_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
         & (sum[GROUP-1] ^ a_q[WIDTH-1]);
    last = (g_q == GW'(NG - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      skip_q  <= '0;
      g_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= ~bi;
            g_q     <= '0;
            skip_q  <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          d_q[base +: GROUP] <= sum[GROUP-1:0];
          skip_q[g_q]        <= p;
          c_q                <= c_d;
          if (last) begin
            bo_q    <= ~c_d;
            ov_q    <= ov_d;
            state_q <= DONE;
          end else begin
            g_q <= g_q + GW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bo        = bo_q;
  assign ov        = ov_q;
  assign skip      = skip_q;

endmodule

// File: tb/tb_skip_subtractor_serial.sv
// Directed-vector bench for skip_subtractor_serial (WIDTH=8, GROUP=4).
// Table of hand-computed results plus backpressure and reset sequences.
module tb_skip_subtractor_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       bi;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bo, ov;
  logic [1:0] skip;

  int checks   = 0;
  int failures = 0;

  skip_subtractor_serial #(.WIDTH(8), .GROUP(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bi       (bi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d        (d),
    .bo       (bo),
    .ov       (ov),
    .skip     (skip)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic [1:0] skip;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one operation, scramble inputs after accept, wait for DONE.
  task automatic start_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic vbi, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = va; b = vb; bi = vbi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = va ^ vb; bi = ~vbi;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] hold_d;
    logic [1:0] hold_s;
    logic       hold_bo;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 2'b00};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 2'b10};
    vecs[2] = '{8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0, 2'b11};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 2'b00};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 2'b01};
    vecs[5] = '{8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11};
    vecs[6] = '{8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0, 2'b01};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0, 2'b00};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; bi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_d", 32'(d), 32'd0);
    chk("reset_bo_ov", {30'd0, bo, ov}, 32'd0);
    chk("reset_skip", 32'(skip), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bi, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_d", i), 32'(d), 32'(vecs[i].d));
      chk($sformatf("v%0d_bo", i), 32'(bo), 32'(vecs[i].bo));
      chk($sformatf("v%0d_ov", i), 32'(ov), 32'(vecs[i].ov));
      chk($sformatf("v%0d_skip", i), 32'(skip), 32'(vecs[i].skip));
      release_op();
      chk($sformatf("v%0d_d_kept", i), 32'(d), 32'(vecs[i].d));
    end

    // Backpressure: DONE holds while in_valid pulses with new operands.
    start_op(8'h5A, 8'h3C, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd2);
    hold_d = d; hold_s = skip; hold_bo = bo;
    chk("bp_d", 32'(hold_d), 32'h1E);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0] ? 1'b0 : 1'b1;
      a = 8'h11 * 8'(k + 1); b = 8'h0F; bi = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_d_stable", 32'(d), 32'(hold_d));
      chk("bp_skip_bo_stable", {29'd0, skip, bo},
          {29'd0, hold_s, hold_bo});
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_op();
    start_op(8'h80, 8'h01, 1'b0, lat);
    chk("bp_next_latency", 32'(lat), 32'd2);
    chk("bp_next_d", 32'(d), 32'h7F);
    chk("bp_next_ov", 32'(ov), 32'd1);
    release_op();

    // Reset in the first BUSY cycle discards the operation.
    @(negedge clk);
    a = 8'h00; b = 8'h01; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_mid_busy_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_d", 32'(d), 32'd0);
    chk("rst_mid_bo", 32'(bo), 32'd0);
    chk("rst_mid_skip", 32'(skip), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst_no_stale_valid", 32'(out_valid), 32'd0);
      chk("rst_idle_in_ready", 32'(in_ready), 32'd1);
    end

    start_op(8'h33, 8'h33, 1'b1, lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_d", 32'(d), 32'hFF);
    chk("post_rst_skip", 32'(skip), 32'h3);
    release_op();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
